// File: rtl/watch_mode_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : watch_mode_ctrl
// Purpose  : Button conditioning, mode select and alarm/timer buzzer arbitration
// Revision : 1.0
// =============================================================================
module watch_mode_ctrl #(
    parameter int DEBOUNCE     = 250000,
    parameter int ALERT_CYCLES = 30000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       enter_i,
    input  logic       esc_i,
    input  logic [6:0] norm,
    input  logic [6:0] alarm_req,
    output logic [6:0] mode,
    output logic [2:0] mode_idx,
    output logic       up_p,
    output logic       down_p,
    output logic       left_p,
    output logic       right_p,
    output logic       enter_p,
    output logic       esc_p,
    output logic       alarm,
    output logic [2:0] alarm_src,
    output logic [6:0] alarm_ack
);

    localparam int CW = $clog2(DEBOUNCE);
    localparam int TW = $clog2(ALERT_CYCLES);
    localparam logic [CW-1:0] c_DB_LAST    = CW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] c_ALERT_LAST = TW'(ALERT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_ALERT  = 1'b1
    } state_t;

    // Bit order everywhere: {esc, enter, right, left, down, up}
    logic [5:0] w_raw;
    logic [5:0] w_ev;

    assign w_raw = {esc_i, enter_i, right_i, left_i, down_i, up_i};

    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
        logic          r_s1;
        logic          r_s2;
        logic          r_db;
        logic          r_ev;
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_db  <= 1'b0;
                r_ev  <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= ~w_raw[gi];
                r_s2 <= r_s1;
                r_ev <= 1'b0;
                if (r_s2 != r_db) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                        r_ev  <= r_s2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_ev[gi] = r_ev;
    end

    state_t        r_state;
    logic [2:0]    r_mode_idx;
    logic [5:0]    r_p;
    logic          r_alarm;
    logic [2:0]    r_src;
    logic [6:0]    r_ack;
    logic [6:0]    r_pending;
    logic [6:0]    r_req;
    logic [6:0]    r_req_d;
    logic [TW-1:0] r_timer;

    logic [6:0]    w_rise;
    logic [6:0]    w_rise_eff;
    logic [6:0]    w_src_oh;
    logic [6:0]    w_clr;
    logic          w_ack_now;
    logic [2:0]    w_low_idx;
    logic          w_norm_ok;
    logic [2:0]    w_idx_inc;
    logic [2:0]    w_idx_dec;

    assign w_rise    = r_req & ~r_req_d;
    assign w_src_oh  = 7'b0000001 << r_src;
    assign w_ack_now = (r_state == S_ALERT) && ((|w_ev) || (r_timer == c_ALERT_LAST));
    // The source being alerted cannot re-arm itself while its alert is live
    assign w_rise_eff = (r_state == S_ALERT) ? (w_rise & ~w_src_oh) : w_rise;
    assign w_clr      = w_ack_now ? w_src_oh : 7'b0000000;
    assign w_norm_ok  = norm[r_mode_idx];
    assign w_idx_inc  = (r_mode_idx == 3'd6) ? 3'd0 : r_mode_idx + 3'd1;
    assign w_idx_dec  = (r_mode_idx == 3'd0) ? 3'd6 : r_mode_idx - 3'd1;

    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_NORMAL;
            r_mode_idx <= 3'd0;
            r_p        <= 6'b000000;
            r_alarm    <= 1'b0;
            r_src      <= 3'd0;
            r_ack      <= 7'b0000000;
            r_pending  <= 7'b0000000;
            r_req      <= 7'b0000000;
            r_req_d    <= 7'b0000000;
            r_timer    <= '0;
        end else begin
            r_req     <= alarm_req;
            r_req_d   <= r_req;
            r_pending <= (r_pending | w_rise_eff) & ~w_clr;
            r_p       <= 6'b000000;
            r_ack     <= 7'b0000000;
            case (r_state)
                S_NORMAL: begin
                    if (|r_pending) begin
                        // Entering ALERT swallows any button event of this cycle
                        r_state <= S_ALERT;
                        r_alarm <= 1'b1;
                        r_src   <= w_low_idx;
                        r_timer <= '0;
                    end else begin
                        if (w_ev[0]) begin
                            if (w_norm_ok) r_mode_idx <= w_idx_inc;
                            else           r_p[0]     <= 1'b1;
                        end else if (w_ev[1]) begin
                            if (w_norm_ok) r_mode_idx <= w_idx_dec;
                            else           r_p[1]     <= 1'b1;
                        end
                        r_p[5:2] <= w_ev[5:2];
                    end
                end
                S_ALERT: begin
                    if (w_ack_now) begin
                        r_state <= S_NORMAL;
                        r_alarm <= 1'b0;
                        r_ack   <= w_src_oh;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_NORMAL;
            endcase
        end
    end

    assign mode      = 7'b0000001 << r_mode_idx;
    assign mode_idx  = r_mode_idx;
    assign up_p      = r_p[0];
    assign down_p    = r_p[1];
    assign left_p    = r_p[2];
    assign right_p   = r_p[3];
    assign enter_p   = r_p[4];
    assign esc_p     = r_p[5];
    assign alarm     = r_alarm;
    assign alarm_src = r_src;
    assign alarm_ack = r_ack;

endmodule
`default_nettype wire
